// File: rtl/io_ff_pkg.sv
// Shared types for the IO flip-flop bank.
//   io_ff_mode_e : per-channel run-time mode (bypass / registered / hold / synchroniser)
//   IOFF_MODE_W  : width of a mode word
package io_ff_pkg;

    localparam int unsigned IOFF_MODE_W = 2;

    typedef enum logic [IOFF_MODE_W-1:0] {
        IOFF_BYPASS = 2'b00,
        IOFF_REG    = 2'b01,
        IOFF_HOLD   = 2'b10,
        IOFF_SYNC   = 2'b11
    } io_ff_mode_e;

endpackage

// File: rtl/io_ff_channel.sv
// One IO channel: DEPTH-stage pipeline, a mode register written via bl/wl, and a scan segment.
// Ports:
//   ff_clk, global_resetn : clock, async active-low reset
//   scan_en, scan_in      : scan shift enable and serial input (from previous segment)
//   scan_out              : serial output (last stage of this channel)
//   d, en                 : functional data in, HOLD-mode capture enable
//   bl, wl                : mode word and write strobe
//   q                     : functional data out
//   mode                  : current mode word
module io_ff_channel
    import io_ff_pkg::*;
#(
    parameter int unsigned            DEPTH    = 2,
    parameter logic [IOFF_MODE_W-1:0] MODE_RST = 2'b00
) (
    input  logic                   ff_clk,
    input  logic                   global_resetn,
    input  logic                   scan_en,
    input  logic                   scan_in,
    output logic                   scan_out,
    input  logic                   d,
    input  logic                   en,
    input  logic [IOFF_MODE_W-1:0] bl,
    input  logic                   wl,
    output logic                   q,
    output logic [IOFF_MODE_W-1:0] mode
);

    // stage_q[0] is stage s0 (input side), stage_q[DEPTH-1] the last stage.
    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;
    io_ff_mode_e      mode_q;

    always_comb begin
        stage_d = stage_q;
        if (scan_en) begin
            // Scan overrides mode and enable: every flop shifts.
            stage_d = {stage_q[DEPTH-2:0], scan_in};
        end else begin
            unique case (mode_q)
                // BYPASS still shifts d so the stages stay scan-observable.
                IOFF_BYPASS, IOFF_REG: stage_d = {stage_q[DEPTH-2:0], d};
                IOFF_HOLD: begin
                    if (en) begin
                        stage_d = {stage_q[DEPTH-2:0], d};
                    end
                end
                // Two-flop synchroniser; stages >= 2 keep their contents.
                IOFF_SYNC: stage_d[1:0] = {stage_q[0], d};
                default:   stage_d = stage_q;
            endcase
        end
    end

    always_ff @(posedge ff_clk or negedge global_resetn) begin
        if (!global_resetn) begin
            stage_q <= '0;
            mode_q  <= io_ff_mode_e'(MODE_RST);
        end else begin
            stage_q <= stage_d;
            if (wl) begin
                mode_q <= io_ff_mode_e'(bl);
            end
        end
    end

    always_comb begin
        q = 1'b0;
        unique case (mode_q)
            IOFF_BYPASS:         q = d;
            IOFF_REG, IOFF_HOLD: q = stage_q[DEPTH-1];
            IOFF_SYNC:           q = stage_q[1];
            default:             q = 1'b0;
        endcase
    end

    assign scan_out = stage_q[DEPTH-1];
    assign mode     = mode_q;

endmodule

// File: rtl/io_ff_bank.sv
// Multi-channel IO register bank between the iopad and the routing mux.
// NUM_CH independent channels, each with a DEPTH-stage pipeline and a run-time mode.
// All stages form one scan chain: ch0.s0 .. ch0.s(DEPTH-1) -> ch1.s0 .. -> ff_SO.
// Ports:
//   ff_clk, global_resetn : clock, async active-low reset
//   scan_en, ff_SI, ff_SO : scan control, chain head and tail
//   ff_D, ff_en           : per-channel functional data and HOLD enable
//   bl, wl                : mode word and per-channel write strobes
//   ff_Q                  : per-channel functional output
//   mode_q                : per-channel mode, channel i at [2i+1:2i]
module io_ff_bank
    import io_ff_pkg::*;
#(
    parameter int unsigned            NUM_CH   = 4,
    parameter int unsigned            DEPTH    = 2,
    parameter logic [IOFF_MODE_W-1:0] MODE_RST = 2'b00
) (
    input  logic                          ff_clk,
    input  logic                          global_resetn,
    input  logic                          scan_en,
    input  logic                          ff_SI,
    output logic                          ff_SO,
    input  logic [NUM_CH-1:0]             ff_D,
    input  logic [NUM_CH-1:0]             ff_en,
    input  logic [IOFF_MODE_W-1:0]        bl,
    input  logic [NUM_CH-1:0]             wl,
    output logic [NUM_CH-1:0]             ff_Q,
    output logic [IOFF_MODE_W*NUM_CH-1:0] mode_q
);

    // chain[i] feeds channel i; chain[NUM_CH] is the tail.
    logic [NUM_CH:0] chain;

    assign chain[0] = ff_SI;
    assign ff_SO    = chain[NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        io_ff_channel #(
            .DEPTH    (DEPTH),
            .MODE_RST (MODE_RST)
        ) u_ch (
            .ff_clk        (ff_clk),
            .global_resetn (global_resetn),
            .scan_en       (scan_en),
            .scan_in       (chain[i]),
            .scan_out      (chain[i+1]),
            .d             (ff_D[i]),
            .en            (ff_en[i]),
            .bl            (bl),
            .wl            (wl[i]),
            .q             (ff_Q[i]),
            .mode          (mode_q[IOFF_MODE_W*i +: IOFF_MODE_W])
        );
    end

endmodule
